// File: rtl/display_scan_if.sv
// Signal bundle between the time source/display consumer and display_scan.
// The master side supplies time values and blanking; the slave side drives the LED pins and busy.
interface display_scan_if #(
  parameter int IN_WIDTH = 6
);
  logic [IN_WIDTH-1:0] minutes;
  logic [IN_WIDTH-1:0] seconds;
  logic                blank;
  logic [6:0]          seg;
  logic [3:0]          an;
  logic                dp;
  logic                busy;

  modport master (
    output minutes, seconds, blank,
    input  seg, an, dp, busy
  );

  modport slave (
    input  minutes, seconds, blank,
    output seg, an, dp, busy
  );
endinterface

// File: rtl/display_scan.sv
// Four-digit multiplexed mm.ss display driver.
// It converts binary minutes/seconds to BCD by repeated subtraction once per frame and scans the digits.
module display_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int IN_WIDTH = 6
) (
  input  logic           clk,
  input  logic           reset_n,
  display_scan_if.slave  io
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IN_WIDTH-1:0] TEN = IN_WIDTH'(10);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CONV_S,
    S_CONV_M,
    S_DONE
  } state_t;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic                first_q;
  logic                start_q;
  state_t              state_q;
  logic [IN_WIDTH-1:0] snap_s_q, snap_m_q;
  logic [IN_WIDTH-1:0] rem_s_q, rem_m_q;
  logic [IN_WIDTH-1:0] ten_s_q, ten_m_q;
  logic [3:0]          su_q, st_q, mu_q, mt_q;
  logic [6:0]          seg_q;
  logic [3:0]          an_q;
  logic                dp_q;
  logic                scan_tick;
  logic                frame_start;
  logic                busy;
  logic                accept;
  logic [3:0]          cur_digit;

  // Values above 9 map to the dark code; IN_WIDTH is assumed to be at least 4.
  function automatic logic [3:0] to_digit(input logic [IN_WIDTH-1:0] v);
    return (v > IN_WIDTH'(9)) ? 4'hF : v[3:0];
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign scan_tick   = (cnt_q == CW'(SCAN_DIV - 1));
  assign frame_start = first_q || (scan_tick && (idx_q == 2'd3));
  // The accepted-start cycle counts as busy so a second start cannot slip in before LOAD.
  assign busy        = start_q || (state_q != S_IDLE);
  assign accept      = frame_start && !busy;

  always_comb begin
    cnt_d = scan_tick ? '0 : cnt_q + CW'(1);
    idx_d = scan_tick ? idx_q + 2'd1 : idx_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      first_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      first_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      su_q    <= 4'd0;
      st_q    <= 4'd0;
      mu_q    <= 4'd0;
      mt_q    <= 4'd0;
    end else begin
      start_q <= accept;
      if (accept) begin
        snap_s_q <= io.seconds;
        snap_m_q <= io.minutes;
      end
      case (state_q)
        S_IDLE: begin
          if (start_q) state_q <= S_LOAD;
        end
        S_LOAD: begin
          rem_s_q <= snap_s_q;
          rem_m_q <= snap_m_q;
          ten_s_q <= '0;
          ten_m_q <= '0;
          state_q <= S_CONV_S;
        end
        S_CONV_S: begin
          if (rem_s_q >= TEN) begin
            rem_s_q <= rem_s_q - TEN;
            ten_s_q <= ten_s_q + IN_WIDTH'(1);
          end else begin
            state_q <= S_CONV_M;
          end
        end
        S_CONV_M: begin
          if (rem_m_q >= TEN) begin
            rem_m_q <= rem_m_q - TEN;
            ten_m_q <= ten_m_q + IN_WIDTH'(1);
          end else begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          su_q    <= to_digit(rem_s_q);
          st_q    <= to_digit(ten_s_q);
          mu_q    <= to_digit(rem_m_q);
          mt_q    <= to_digit(ten_m_q);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cur_digit = su_q;
    case (idx_q)
      2'd1:    cur_digit = st_q;
      2'd2:    cur_digit = mu_q;
      2'd3:    cur_digit = mt_q;
      default: cur_digit = su_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n || io.blank) begin
      an_q  <= 4'hF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= ~(4'b0001 << idx_q);
      seg_q <= seg_encode(cur_digit);
      dp_q  <= (idx_q != 2'd2);
    end
  end

  assign io.seg  = seg_q;
  assign io.an   = an_q;
  assign io.dp   = dp_q;
  assign io.busy = busy;

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan with SCAN_DIV=16: a cycle model predicts scan position and busy,
// and a scoreboard queue holds the time values captured at each frame start until commit.
module tb_display_scan;

  localparam int DIV = 16;

  typedef struct {
    int s;
    int m;
  } entry_t;

  logic clk;
  logic reset_n;

  display_scan_if #(.IN_WIDTH(6)) dif ();

  display_scan #(.SCAN_DIV(DIV), .IN_WIDTH(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     left = 0;
  int     run_len = 0;
  bit     prev_busy = 1'b0;
  int     shown_s = 0;
  int     shown_m = 0;
  entry_t sb_q[$];

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic sample();
    int     idx;
    int     dig;
    bit     frame;
    entry_t e;
    if (!reset_n) begin
      chk("rst_an", int'(dif.an), 'hF);
      chk("rst_seg", int'(dif.seg), 'h7F);
      chk("rst_dp", int'(dif.dp), 1);
      chk("rst_busy", int'(dif.busy), 0);
      cyc = 0;
      left = 0;
      run_len = 0;
      prev_busy = 1'b0;
      shown_s = 0;
      shown_m = 0;
      sb_q.delete();
      return;
    end
    cyc++;
    // Displayed digit reflects the index and committed value held before this edge.
    idx = ((cyc - 1) / DIV) % 4;
    case (idx)
      0:       dig = shown_s % 10;
      1:       dig = shown_s / 10;
      2:       dig = shown_m % 10;
      default: dig = shown_m / 10;
    endcase
    if (dif.blank) begin
      chk("an_blank", int'(dif.an), 'hF);
      chk("seg_blank", int'(dif.seg), 'h7F);
      chk("dp_blank", int'(dif.dp), 1);
    end else begin
      chk("an", int'(dif.an), (~(1 << idx)) & 'hF);
      chk("seg", int'(dif.seg), int'(seg_tab[dig]));
      chk("dp", int'(dif.dp), (idx == 2) ? 0 : 1);
    end
    if (prev_busy && !dif.busy) begin
      chk("sb_pending", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("busy_len", run_len, 5 + e.s / 10 + e.m / 10);
        shown_s = e.s;
        shown_m = e.m;
      end
    end
    frame = (cyc == 1) || ((cyc % (4 * DIV)) == 0);
    if (frame && left == 0) begin
      e.s = int'(dif.seconds);
      e.m = int'(dif.minutes);
      sb_q.push_back(e);
      left = 5 + e.s / 10 + e.m / 10;
    end
    chk("busy", int'(dif.busy), (left > 0) ? 1 : 0);
    if (left > 0) left--;
    run_len = dif.busy ? (prev_busy ? run_len + 1 : 1) : 0;
    prev_busy = dif.busy;
  endtask

  task automatic step();
    @(negedge clk);
    sample();
  endtask

  task automatic run_until(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 5000) begin
      step();
      guard++;
    end
    chk("run_bound", int'(cyc >= c), 1);
  endtask

  initial begin
    reset_n     = 1'b0;
    dif.minutes = 6'd0;
    dif.seconds = 6'd0;
    dif.blank   = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    run_until(140);

    dif.minutes = 6'd59;
    dif.seconds = 6'd32;
    run_until(196);
    // Change arrives mid-conversion; the snapshot keeps 32 for this frame.
    dif.seconds = 6'd33;
    run_until(300);

    dif.blank = 1'b1;
    repeat (20) step();
    dif.blank = 1'b0;
    run_until(340);

    dif.minutes = 6'd63;
    dif.seconds = 6'd63;
    run_until(470);

    dif.minutes = 6'd59;
    dif.seconds = 6'd32;
    run_until(520);
    // Reset lands while the minutes field is being converted.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    run_until(100);
    chk("final_shown_s", shown_s, 32);
    chk("final_shown_m", shown_m, 59);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
